// File: rtl/alu_sequencer_if.sv
// Request, ALU handshake and datapath strobe bundle between a driver (master) and alu_sequencer (slave).
// The master owns the request fields and alu_done; the slave owns every strobe and status output.
interface alu_sequencer_if #(
    parameter int REG_W = 4,
    parameter int OP_W  = 4
);
    logic             start;
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic             alu_done;

    logic             busy;
    logic             done;
    logic             illegal;
    logic [REG_W-1:0] reg_sel;
    logic             reg_out;
    logic             reg_in;
    logic             y_in;
    logic             z_in;
    logic             z_lo_out;
    logic             z_hi_out;
    logic             lo_in;
    logic             hi_in;
    logic [OP_W-1:0]  alu_op;
    logic             alu_start;

    modport master (
        output start, opcode, ra, rb, rc, alu_done,
        input  busy, done, illegal, reg_sel, reg_out, reg_in, y_in, z_in,
               z_lo_out, z_hi_out, lo_in, hi_in, alu_op, alu_start
    );

    modport slave (
        input  start, opcode, ra, rb, rc, alu_done,
        output busy, done, illegal, reg_sel, reg_out, reg_in, y_in, z_in,
               z_lo_out, z_hi_out, lo_in, hi_in, alu_op, alu_start
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one register-to-register ALU instruction over the shared bus as a Moore FSM.
// Latency accept->done: binary 4, NEG/NOT 3, MUL/DIV 5+wait cycles, illegal 1; start ignored while busy.
module alu_sequencer #(
    parameter int REG_W = 4,
    parameter int OP_W  = 4
) (
    input  logic            clk,
    input  logic            clr,
    alu_sequencer_if.slave  bus
);
    localparam logic [OP_W-1:0] OP_NEG = OP_W'(2);
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(6);
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(7);

    typedef enum logic [3:0] {
        IDLE, T_Y, T_OP, T_WAIT, T_WB, T_LO, T_HI, T_DONE, T_ERR
    } state_t;

    state_t           state, state_nx;
    logic [OP_W-1:0]  op_q;
    logic [REG_W-1:0] ra_q, rb_q, rc_q;

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op <= OP_DIV;
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                op_q <= bus.opcode;
                ra_q <= bus.ra;
                rb_q <= bus.rb;
                rc_q <= bus.rc;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        bus.busy     = (state != IDLE);
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        bus.reg_sel  = '0;
        bus.reg_out  = 1'b0;
        bus.reg_in   = 1'b0;
        bus.y_in     = 1'b0;
        bus.z_in     = 1'b0;
        bus.z_lo_out = 1'b0;
        bus.z_hi_out = 1'b0;
        bus.lo_in    = 1'b0;
        bus.hi_in    = 1'b0;
        bus.alu_op   = '0;
        bus.alu_start = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!is_legal(bus.opcode))      state_nx = T_ERR;
                    else if (is_unary(bus.opcode))  state_nx = T_OP;
                    else                            state_nx = T_Y;
                end
            end
            T_Y: begin
                bus.reg_sel = rb_q;
                bus.reg_out = 1'b1;
                bus.y_in    = 1'b1;
                state_nx    = T_OP;
            end
            T_OP: begin
                bus.reg_sel = is_unary(op_q) ? rb_q : rc_q;
                bus.reg_out = 1'b1;
                bus.alu_op  = op_q;
                if (is_muldiv(op_q)) begin
                    bus.alu_start = 1'b1;
                    state_nx      = T_WAIT;
                end else begin
                    bus.z_in = 1'b1;
                    state_nx = T_WB;
                end
            end
            T_WAIT: begin
                // z_in is the only output allowed to follow an input within the cycle
                bus.reg_sel = rc_q;
                bus.reg_out = 1'b1;
                bus.alu_op  = op_q;
                if (bus.alu_done) begin
                    bus.z_in = 1'b1;
                    state_nx = T_LO;
                end
            end
            T_WB: begin
                bus.z_lo_out = 1'b1;
                bus.reg_sel  = ra_q;
                bus.reg_in   = 1'b1;
                state_nx     = T_DONE;
            end
            T_LO: begin
                bus.z_lo_out = 1'b1;
                bus.lo_in    = 1'b1;
                state_nx     = T_HI;
            end
            T_HI: begin
                bus.z_hi_out = 1'b1;
                bus.hi_in    = 1'b1;
                state_nx     = T_DONE;
            end
            T_DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            T_ERR: begin
                bus.done    = 1'b1;
                bus.illegal = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer: expected strobes per cycle are derived from
// instruction class and cycle index after accept, not from any state encoding.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_sequencer_if #(.REG_W(4), .OP_W(4)) bus ();

    alu_sequencer #(.REG_W(4), .OP_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {bus.busy, bus.done, bus.illegal, bus.reg_out, bus.reg_in, bus.y_in,
                  bus.z_in, bus.z_lo_out, bus.z_hi_out, bus.lo_in, bus.hi_in, bus.alu_start};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Called at posedge+1 of the cycle in which start is presented; returns at posedge+1 with the DUT idle.
    task automatic run(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input int n, input int abort_c);
        bit bin, un, md, ill, wb, wait_c;
        int L, opc;
        logic [11:0] e;
        logic [3:0]  esel;

        ill = (op > 4'd7);
        un  = (op == 4'd2) || (op == 4'd3);
        md  = (op == 4'd6) || (op == 4'd7);
        bin = !ill && !un;
        L   = ill ? 1 : un ? 3 : md ? 5 + n : 4;
        opc = un ? 1 : 2;

        bus.start = 1'b1; bus.opcode = op; bus.ra = ra; bus.rb = rb; bus.rc = rc;
        bus.alu_done = 1'($urandom);
        @(negedge clk);
        chk("idle_outputs", 32'(obs), 32'd0);

        for (int c = 1; c <= L; c++) begin
            @(posedge clk); #1;
            bus.start  = 1'($urandom);
            bus.opcode = 4'($urandom);
            bus.ra = 4'($urandom); bus.rb = 4'($urandom); bus.rc = 4'($urandom);
            if (md && c > 2 && c <= 2 + n) bus.alu_done = (c == 2 + n);
            else                           bus.alu_done = 1'($urandom);

            if (c == abort_c) begin
                clr = 1'b1;
                #1;
                chk("clr_abort_strobes", 32'(obs), 32'd0);
                chk("clr_abort_reg_sel", 32'(bus.reg_sel), 32'd0);
                chk("clr_abort_alu_op", 32'(bus.alu_op), 32'd0);
                @(negedge clk);
                clr = 1'b0;
                bus.start = 1'b0;
                @(posedge clk); #1;
                return;
            end

            @(negedge clk);
            wb     = !ill && !md && (c == L - 1);
            wait_c = md && (c > 2) && (c <= 2 + n);
            e[11] = 1'b1;
            e[10] = (c == L);
            e[9]  = (c == L) && ill;
            e[8]  = !ill && ((bin && c == 1) || c == opc || wait_c);
            e[7]  = wb;
            e[6]  = bin && (c == 1);
            e[5]  = !ill && (md ? (c == 2 + n) : (c == opc));
            e[4]  = wb || (md && c == L - 2);
            e[3]  = md && (c == L - 1);
            e[2]  = md && (c == L - 2);
            e[1]  = md && (c == L - 1);
            e[0]  = md && (c == 2);
            chk($sformatf("strobes_op%0d_c%0d", op, c), 32'(obs), 32'(e));
            chk("one_bus_driver",
                32'((int'(bus.reg_out) + int'(bus.z_lo_out) + int'(bus.z_hi_out)) <= 1), 32'd1);

            if (e[8] || e[7]) begin
                if (bin && c == 1)  esel = rb;
                else if (c == opc)  esel = un ? rb : rc;
                else if (wait_c)    esel = rc;
                else                esel = ra;
                chk($sformatf("reg_sel_op%0d_c%0d", op, c), 32'(bus.reg_sel), 32'(esel));
            end
            if (!ill && (c == opc || wait_c))
                chk($sformatf("alu_op_op%0d_c%0d", op, c), 32'(bus.alu_op), 32'(op));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.start = 1'b0; bus.opcode = '0; bus.ra = '0; bus.rb = '0; bus.rc = '0;
        bus.alu_done = 1'b0;

        @(negedge clk);
        chk("reset_strobes", 32'(obs), 32'd0);
        chk("reset_reg_sel", 32'(bus.reg_sel), 32'd0);
        chk("reset_alu_op", 32'(bus.alu_op), 32'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        run(4'd4, 4'd3, 4'd1, 4'd2, 0, 0);    // ADD
        run(4'd3, 4'd5, 4'd7, 4'd9, 0, 0);    // NOT
        run(4'd6, 4'd8, 4'd4, 4'd6, 3, 0);    // MUL, 3 wait cycles
        run(4'd12, 4'd1, 4'd2, 4'd3, 0, 0);   // illegal
        run(4'd5, 4'd10, 4'd11, 4'd12, 0, 0); // SUB with start noise while busy
        run(4'd7, 4'd2, 4'd3, 4'd4, 5, 4);    // DIV aborted by clr in T_WAIT
        run(4'd0, 4'd6, 4'd14, 4'd15, 0, 0);  // AND after abort
        run(4'd7, 4'd1, 4'd5, 4'd9, 1, 0);    // DIV, alu_done in first wait cycle

        for (int i = 0; i < 60; i++)
            run(4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                int'($urandom_range(1, 6)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that sequences one register-to-register ALU instruction over the single shared bus of the phase-1 datapath. It accepts a decoded request (opcode, destination and source register indices) and emits the one-hot strobes that move operands through Y, the ALU and Z, then back into the register file or HI/LO. Multiply and divide use a handshake with the multi-cycle ALU unit. It sits between the instruction decoder or testbench driver and the bus/register-file/ALU datapath.

## Interface
Parameters:
- REG_W, 4, width of register index (16 GPRs)
- OP_W, 4, width of opcode field

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-high reset
- start  in  1  request valid; sampled only in IDLE
- opcode  in  OP_W  0=AND 1=OR 2=NEG 3=NOT 4=ADD 5=SUB 6=MUL 7=DIV; 8-15 illegal
- ra  in  REG_W  destination register
- rb  in  REG_W  first/only source register
- rc  in  REG_W  second source register (ignored for NEG/NOT)
- alu_done  in  1  multi-cycle ALU result ready (MUL/DIV)
- busy  out  1  high from accept cycle+1 through the done cycle
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse, coincident with done, for illegal opcode
- reg_sel  out  REG_W  register index addressed this cycle
- reg_out  out  1  selected register drives bus
- reg_in  out  1  selected register loads from bus
- y_in, z_in, z_lo_out, z_hi_out, lo_in, hi_in  out  1 each  datapath strobes
- alu_op  out  OP_W  operation presented to ALU
- alu_start  out  1  one-cycle pulse launching MUL/DIV

## Operation
- Request fields (opcode, ra, rb, rc) latched on accept; inputs may change afterward.
- States: IDLE, T_Y, T_OP, T_WAIT, T_WB, T_LO, T_HI, T_DONE, T_ERR.
- IDLE: all strobes 0; start=1 -> legal binary op (AND/OR/ADD/SUB/MUL/DIV) to T_Y; NEG/NOT to T_OP; illegal to T_ERR.
- T_Y: reg_sel=rb, reg_out, y_in -> T_OP.
- T_OP binary: reg_sel=rc, reg_out, alu_op=op, z_in. Unary: reg_sel=rb, reg_out, alu_op=op, z_in. MUL/DIV: alu_start=1, no z_in -> T_WAIT; others -> T_WB.
- T_WAIT: alu_op held; reg_sel=rc, reg_out held; z_in asserted in the cycle alu_done=1, then -> T_LO. alu_done ignored outside T_WAIT.
- T_WB: z_lo_out, reg_sel=ra, reg_in -> T_DONE.
- T_LO: z_lo_out, lo_in -> T_HI. T_HI: z_hi_out, hi_in -> T_DONE (ra ignored for MUL/DIV).
- T_DONE: done=1 -> IDLE. T_ERR: done=1, illegal=1, no datapath strobes -> IDLE.
- At most one of reg_out, z_lo_out, z_hi_out asserted in any cycle (single bus driver invariant).
- All outputs combinational from state and latched fields only (Moore); no input-to-output paths except z_in in T_WAIT.

## Timing
- Reset: state=IDLE; busy, done, illegal, all strobes, alu_start = 0; reg_sel=0; alu_op=0; latched fields=0.
- clr mid-operation aborts immediately; no partial write-back completes after clr rises.
- Latency from accept edge to done cycle: binary ALU op 4 cycles (T_Y, T_OP, T_WB, T_DONE); NEG/NOT 3; MUL/DIV 5 + N, N = cycles in T_WAIT (N≥1, alu_done may be high in first T_WAIT cycle); illegal 1.
- start while busy ignored; back-to-back: start high in the cycle after done is accepted (IDLE reached).
- alu_start is exactly one cycle per MUL/DIV; alu_done stuck low holds T_WAIT indefinitely (no timeout).

## Test plan
- ADD ra=3 rb=1 rc=2: T_Y reg_sel=1 reg_out y_in; T_OP reg_sel=2 alu_op=4 z_in; T_WB reg_sel=3 reg_in z_lo_out; done 4 cycles after accept.
- NOT ra=5 rb=7: T_OP reg_sel=7 alu_op=3 z_in, no y_in ever; T_WB reg_sel=5; done after 3 cycles.
- MUL rb=4 rc=6 with alu_done after 3 wait cycles: single alu_start pulse, z_in only in alu_done cycle, then lo_in, hi_in in consecutive cycles, no reg_in; done after 8 cycles.
- opcode=12: one cycle later done=illegal=1, all strobes 0, back to IDLE; start during a running SUB ignored with fields unchanged.
- Assert clr during T_WAIT of DIV: all outputs 0 asynchronously, state IDLE; subsequent AND completes normally in 4 cycles.
- Random legal stream: checker confirms single-bus-driver invariant and busy/done accounting every cycle.
